lives_counter: RTL and testbench
================================

Name: lives_counter

Overview:
- Produces the 3-bit deaths/lives count that the game-over comparator consumes. The comparator flags game over at count == 5.
- Counts frog deaths from collision and out-of-time events, and runs a respawn hold-off after each death.
- Grants bonus lives on level completion.
- Sits between the collision/timer logic and the lives comparator in the game top level.

Parameters:
- LIVES_COUNTER_DATAWIDTH, 3, width of count output; must hold MAX_DEATHS.
- MAX_DEATHS, 5, count value that means game over; matches the comparator constant.
- HOLDOFF_CYCLES, 50000000, respawn hold-off length in clocks (1 s at 50 MHz); minimum 2.
- HOLDOFF_WIDTH, 26, width of hold-off timer; must satisfy 2^HOLDOFF_WIDTH > HOLDOFF_CYCLES.

Ports:
- LIVES_COUNTER_CLOCK_50  in  1  system clock, 50 MHz.
- LIVES_COUNTER_RESET_InHigh  in  1  synchronous reset, active-high.
- LIVES_COUNTER_death_InHigh  in  1  death request (collision OR timer expired); level, may stay high for many cycles.
- LIVES_COUNTER_bonus_InHigh  in  1  level-complete pulse; restores one life.
- LIVES_COUNTER_restart_InHigh  in  1  new-game request; honoured only in GAME_OVER.
- LIVES_COUNTER_count_Out  out  LIVES_COUNTER_DATAWIDTH  deaths so far; feeds the comparator input.
- LIVES_COUNTER_respawn_OutHigh  out  1  one-cycle pulse when the frog must return to its start position.
- LIVES_COUNTER_dying_OutHigh  out  1  high during hold-off; sprite blink and input freeze.
- LIVES_COUNTER_gameover_OutHigh  out  1  high in GAME_OVER.

Behaviour:
- All state is updated on the rising clock edge. Reset is synchronous and has priority over every other input.
- Reset values:
  - count = 0, respawn = 0, dying = 0, gameover = 0.
  - state = PLAYING, hold-off timer = 0, death edge register = 0.
- Death edge detect: rise = death & ~death_d, where death_d is the death input registered every cycle (including during hold-off and GAME_OVER). A death held high counts once.
- State PLAYING:
  - On rise: count <= count+1, timer <= 0, respawn pulse is not issued.
    - If count+1 == MAX_DEATHS: go to GAME_OVER.
    - Otherwise: go to DYING.
  - On bonus with no rise: count <= count-1, saturating at 0.
  - Rise and bonus in the same cycle: death wins and the bonus is discarded.
- State DYING:
  - dying = 1.
  - Timer increments each cycle. Death and bonus inputs are ignored (invulnerable).
  - When timer == HOLDOFF_CYCLES-1: respawn = 1 for exactly that cycle's next registered output, dying = 0, go to PLAYING.
  - Net effect: dying is high for HOLDOFF_CYCLES cycles, and respawn is asserted on the first PLAYING cycle.
- State GAME_OVER:
  - gameover = 1, count holds MAX_DEATHS.
  - Death and bonus inputs are ignored.
  - restart: count <= 0, gameover <= 0, respawn pulse 1 cycle, go to PLAYING.
- Latency: count, dying and gameover change on the same edge that samples the death rise (one-cycle registered latency from input change).
- All outputs are registered; no combinational input-to-output path.
- Count never exceeds MAX_DEATHS and never underflows below 0.
- Reset asserted mid-DYING or mid-GAME_OVER returns to reset values on the next edge; no respawn pulse is generated.
- restart in PLAYING or DYING is ignored.

Decomposition:
- Shared game package holds:
  - state encoding: PLAYING=2'b00, DYING=2'b01, GAME_OVER=2'b10 (2'b11 recovers to PLAYING);
  - MAX_DEATHS = 5, shared with the comparator so both ends agree;
  - HOLDOFF_CYCLES default.
- One natural sub-module: lives_holdoff_timer (load/enable counter with done flag).
- Edge detect and FSM stay in the top module.

Test Plan (HOLDOFF_CYCLES=4):
- Reset, then single-cycle death pulse:
  - count 0->1 on the sampling edge;
  - dying high for 4 cycles, then respawn high for 1 cycle;
  - gameover stays 0.
- Death held high for 20 cycles:
  - count increments exactly once to 1;
  - after hold-off, with death still high, no further increment until death drops and rises again.
- Five separated deaths:
  - count reaches 5, gameover=1, dying=0, no respawn pulse;
  - further deaths and bonuses leave count=5;
  - restart -> count=0, gameover=0, 1-cycle respawn.
- Bonus at count=2 -> count=1; bonus at count=0 -> stays 0; bonus during DYING -> ignored.
- Death and bonus asserted in the same PLAYING cycle: count 1->2, enters DYING.
- Reset asserted in the 2nd DYING cycle: next edge gives count=0, dying=0, respawn=0, state PLAYING.

Source files
------------

// File: rtl/lives_counter_pkg.sv
// Shared game constants and lives-counter state encoding.
// The game-over comparator imports LIVES_MAX_DEATHS so both ends agree on the limit.
package lives_counter_pkg;

    typedef enum logic [1:0] {
        PLAYING   = 2'b00,
        DYING     = 2'b01,
        GAME_OVER = 2'b10
    } livesState_t;

    localparam int LIVES_MAX_DEATHS     = 5;
    localparam int LIVES_HOLDOFF_CYCLES = 50000000;
    localparam int LIVES_HOLDOFF_WIDTH  = 26;

    // Bonus lives give back a death but never take the count below zero.
    function automatic logic [7:0] satDecrement(input logic [7:0] value);
        return (value == 8'd0) ? 8'd0 : value - 8'd1;
    endfunction

endpackage

// File: rtl/lives_counter_if.sv
// Event inputs and status outputs between the game logic and the lives counter.
interface lives_counter_if #(
    parameter int DATAWIDTH = 3
);
    logic                 LIVES_COUNTER_death_InHigh;
    logic                 LIVES_COUNTER_bonus_InHigh;
    logic                 LIVES_COUNTER_restart_InHigh;
    logic [DATAWIDTH-1:0] LIVES_COUNTER_count_Out;
    logic                 LIVES_COUNTER_respawn_OutHigh;
    logic                 LIVES_COUNTER_dying_OutHigh;
    logic                 LIVES_COUNTER_gameover_OutHigh;

    modport master (
        output LIVES_COUNTER_death_InHigh,
        output LIVES_COUNTER_bonus_InHigh,
        output LIVES_COUNTER_restart_InHigh,
        input  LIVES_COUNTER_count_Out,
        input  LIVES_COUNTER_respawn_OutHigh,
        input  LIVES_COUNTER_dying_OutHigh,
        input  LIVES_COUNTER_gameover_OutHigh
    );

    modport slave (
        input  LIVES_COUNTER_death_InHigh,
        input  LIVES_COUNTER_bonus_InHigh,
        input  LIVES_COUNTER_restart_InHigh,
        output LIVES_COUNTER_count_Out,
        output LIVES_COUNTER_respawn_OutHigh,
        output LIVES_COUNTER_dying_OutHigh,
        output LIVES_COUNTER_gameover_OutHigh
    );
endinterface

// File: rtl/lives_holdoff_timer.sv
// Respawn hold-off counter: load clears it, enable counts up, done flags the last cycle.
module lives_holdoff_timer
    import lives_counter_pkg::*;
#(
    parameter int CYCLES = LIVES_HOLDOFF_CYCLES,
    parameter int WIDTH  = LIVES_HOLDOFF_WIDTH
) (
    input  logic clk,
    input  logic srst,
    input  logic load,
    input  logic enable,
    output logic done
);
    localparam logic [WIDTH-1:0] LAST_VALUE = WIDTH'(CYCLES - 1);

    logic [WIDTH-1:0] timerReg;

    always_ff @(posedge clk) begin
        if (srst) begin
            timerReg <= '0;
        end else if (load) begin
            timerReg <= '0;
        end else if (enable && !done) begin
            timerReg <= timerReg + 1'b1;
        end
    end

    assign done = (timerReg == LAST_VALUE);

endmodule

// File: rtl/lives_counter.sv
// Frog death counter with respawn hold-off, bonus lives and game-over/restart handling.
module lives_counter
    import lives_counter_pkg::*;
#(
    parameter int LIVES_COUNTER_DATAWIDTH = 3,
    parameter int MAX_DEATHS              = LIVES_MAX_DEATHS,
    parameter int HOLDOFF_CYCLES          = LIVES_HOLDOFF_CYCLES,
    parameter int HOLDOFF_WIDTH           = LIVES_HOLDOFF_WIDTH
) (
    input  logic         LIVES_COUNTER_CLOCK_50,
    input  logic         LIVES_COUNTER_RESET_InHigh,
    lives_counter_if.slave livesBus
);
    localparam logic [LIVES_COUNTER_DATAWIDTH-1:0] LAST_LIFE =
        LIVES_COUNTER_DATAWIDTH'(MAX_DEATHS - 1);

    livesState_t                        stateReg;
    logic [LIVES_COUNTER_DATAWIDTH-1:0] countReg;
    logic                               respawnReg;
    logic                               dyingReg;
    logic                               gameoverReg;
    logic                               deathDelayReg;
    logic                               deathRise;
    logic                               timerDone;
    logic [7:0]                         countDecremented;

    assign deathRise        = livesBus.LIVES_COUNTER_death_InHigh & ~deathDelayReg;
    assign countDecremented = satDecrement(8'(countReg));

    // Timer is held at zero while playing so every hold-off starts fresh.
    lives_holdoff_timer #(
        .CYCLES (HOLDOFF_CYCLES),
        .WIDTH  (HOLDOFF_WIDTH)
    ) holdoffTimer (
        .clk    (LIVES_COUNTER_CLOCK_50),
        .srst   (LIVES_COUNTER_RESET_InHigh),
        .load   (stateReg == PLAYING),
        .enable (stateReg == DYING),
        .done   (timerDone)
    );

    always_ff @(posedge LIVES_COUNTER_CLOCK_50) begin
        if (LIVES_COUNTER_RESET_InHigh) begin
            stateReg      <= PLAYING;
            countReg      <= '0;
            respawnReg    <= 1'b0;
            dyingReg      <= 1'b0;
            gameoverReg   <= 1'b0;
            deathDelayReg <= 1'b0;
        end else begin
            // The edge register tracks death in every state so a held death never re-fires.
            deathDelayReg <= livesBus.LIVES_COUNTER_death_InHigh;
            respawnReg    <= 1'b0;

            case (stateReg)
                PLAYING: begin
                    dyingReg    <= 1'b0;
                    gameoverReg <= 1'b0;
                    if (deathRise) begin
                        countReg <= countReg + 1'b1;
                        if (countReg == LAST_LIFE) begin
                            stateReg    <= GAME_OVER;
                            gameoverReg <= 1'b1;
                        end else begin
                            stateReg <= DYING;
                            dyingReg <= 1'b1;
                        end
                    end else if (livesBus.LIVES_COUNTER_bonus_InHigh) begin
                        countReg <= countDecremented[LIVES_COUNTER_DATAWIDTH-1:0];
                    end
                end

                DYING: begin
                    if (timerDone) begin
                        stateReg   <= PLAYING;
                        dyingReg   <= 1'b0;
                        respawnReg <= 1'b1;
                    end
                end

                GAME_OVER: begin
                    if (livesBus.LIVES_COUNTER_restart_InHigh) begin
                        stateReg    <= PLAYING;
                        countReg    <= '0;
                        gameoverReg <= 1'b0;
                        respawnReg  <= 1'b1;
                    end
                end

                default: begin
                    stateReg    <= PLAYING;
                    dyingReg    <= 1'b0;
                    gameoverReg <= 1'b0;
                end
            endcase
        end
    end

    assign livesBus.LIVES_COUNTER_count_Out        = countReg;
    assign livesBus.LIVES_COUNTER_respawn_OutHigh  = respawnReg;
    assign livesBus.LIVES_COUNTER_dying_OutHigh    = dyingReg;
    assign livesBus.LIVES_COUNTER_gameover_OutHigh = gameoverReg;

endmodule

// File: tb/tb_lives_counter.sv
// Directed bench for lives_counter with a 4-cycle hold-off.
module tb_lives_counter;
    import lives_counter_pkg::*;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;

    lives_counter_if #(.DATAWIDTH(3)) bus ();

    lives_counter #(
        .LIVES_COUNTER_DATAWIDTH (3),
        .MAX_DEATHS              (5),
        .HOLDOFF_CYCLES          (4),
        .HOLDOFF_WIDTH           (3)
    ) dut (
        .LIVES_COUNTER_CLOCK_50     (clk),
        .LIVES_COUNTER_RESET_InHigh (rst),
        .livesBus                   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.LIVES_COUNTER_death_InHigh   = 1'b0;
        bus.LIVES_COUNTER_bonus_InHigh   = 1'b0;
        bus.LIVES_COUNTER_restart_InHigh = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // One-cycle death followed by the full hold-off and respawn cycle.
    task automatic death_and_recover();
        bus.LIVES_COUNTER_death_InHigh = 1'b1;
        step();
        bus.LIVES_COUNTER_death_InHigh = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.LIVES_COUNTER_death_InHigh   = 1'b1;
        bus.LIVES_COUNTER_bonus_InHigh   = 1'b0;
        bus.LIVES_COUNTER_restart_InHigh = 1'b0;
        step();
        step();
        testsRun++;
        if (bus.LIVES_COUNTER_count_Out !== 3'd0 || bus.LIVES_COUNTER_respawn_OutHigh !== 1'b0 ||
            bus.LIVES_COUNTER_dying_OutHigh !== 1'b0 || bus.LIVES_COUNTER_gameover_OutHigh !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_state: count=%0d respawn=%b dying=%b gameover=%b, required 0 0 0 0",
                     bus.LIVES_COUNTER_count_Out, bus.LIVES_COUNTER_respawn_OutHigh,
                     bus.LIVES_COUNTER_dying_OutHigh, bus.LIVES_COUNTER_gameover_OutHigh);
        end
        bus.LIVES_COUNTER_death_InHigh = 1'b0;
        rst = 1'b0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_single_death();
        do_reset();
        bus.LIVES_COUNTER_death_InHigh = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            bus.LIVES_COUNTER_death_InHigh = 1'b0;
            testsRun++;
            if (bus.LIVES_COUNTER_count_Out !== 3'd1 || bus.LIVES_COUNTER_dying_OutHigh !== 1'b1 ||
                bus.LIVES_COUNTER_respawn_OutHigh !== 1'b0 || bus.LIVES_COUNTER_gameover_OutHigh !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL single_dying_cycle%0d: count=%0d dying=%b respawn=%b gameover=%b, required 1 1 0 0",
                         c, bus.LIVES_COUNTER_count_Out, bus.LIVES_COUNTER_dying_OutHigh,
                         bus.LIVES_COUNTER_respawn_OutHigh, bus.LIVES_COUNTER_gameover_OutHigh);
            end
        end
        step();
        testsRun++;
        if (bus.LIVES_COUNTER_respawn_OutHigh !== 1'b1 || bus.LIVES_COUNTER_dying_OutHigh !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL single_respawn: respawn=%b dying=%b, required 1 0",
                     bus.LIVES_COUNTER_respawn_OutHigh, bus.LIVES_COUNTER_dying_OutHigh);
        end
        step();
        testsRun++;
        if (bus.LIVES_COUNTER_respawn_OutHigh !== 1'b0 || bus.LIVES_COUNTER_count_Out !== 3'd1) begin
            testsFailed++;
            $display("[TB] FAIL single_after: respawn=%b count=%0d, required 0 1",
                     bus.LIVES_COUNTER_respawn_OutHigh, bus.LIVES_COUNTER_count_Out);
        end
        $display("[TB] test_single_death done");
    endtask

    task automatic test_held_death();
        do_reset();
        bus.LIVES_COUNTER_death_InHigh = 1'b1;
        repeat (20) step();
        testsRun++;
        if (bus.LIVES_COUNTER_count_Out !== 3'd1 || bus.LIVES_COUNTER_dying_OutHigh !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL held_once: count=%0d dying=%b, required 1 0",
                     bus.LIVES_COUNTER_count_Out, bus.LIVES_COUNTER_dying_OutHigh);
        end
        bus.LIVES_COUNTER_death_InHigh = 1'b0;
        step();
        bus.LIVES_COUNTER_death_InHigh = 1'b1;
        step();
        bus.LIVES_COUNTER_death_InHigh = 1'b0;
        testsRun++;
        if (bus.LIVES_COUNTER_count_Out !== 3'd2 || bus.LIVES_COUNTER_dying_OutHigh !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL held_rearm: count=%0d dying=%b, required 2 1",
                     bus.LIVES_COUNTER_count_Out, bus.LIVES_COUNTER_dying_OutHigh);
        end
        $display("[TB] test_held_death done");
    endtask

    task automatic test_game_over();
        do_reset();
        repeat (4) death_and_recover();
        step();
        testsRun++;
        if (bus.LIVES_COUNTER_count_Out !== 3'd4 || bus.LIVES_COUNTER_gameover_OutHigh !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL four_deaths: count=%0d gameover=%b, required 4 0",
                     bus.LIVES_COUNTER_count_Out, bus.LIVES_COUNTER_gameover_OutHigh);
        end
        bus.LIVES_COUNTER_death_InHigh = 1'b1;
        step();
        bus.LIVES_COUNTER_death_InHigh = 1'b0;
        testsRun++;
        if (bus.LIVES_COUNTER_count_Out !== 3'd5 || bus.LIVES_COUNTER_gameover_OutHigh !== 1'b1 ||
            bus.LIVES_COUNTER_dying_OutHigh !== 1'b0 || bus.LIVES_COUNTER_respawn_OutHigh !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL fifth_death: count=%0d gameover=%b dying=%b respawn=%b, required 5 1 0 0",
                     bus.LIVES_COUNTER_count_Out, bus.LIVES_COUNTER_gameover_OutHigh,
                     bus.LIVES_COUNTER_dying_OutHigh, bus.LIVES_COUNTER_respawn_OutHigh);
        end
        step();
        bus.LIVES_COUNTER_death_InHigh = 1'b1;
        step();
        bus.LIVES_COUNTER_death_InHigh = 1'b0;
        bus.LIVES_COUNTER_bonus_InHigh = 1'b1;
        step();
        bus.LIVES_COUNTER_bonus_InHigh = 1'b0;
        testsRun++;
        if (bus.LIVES_COUNTER_count_Out !== 3'd5 || bus.LIVES_COUNTER_gameover_OutHigh !== 1'b1 ||
            bus.LIVES_COUNTER_respawn_OutHigh !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL over_ignores: count=%0d gameover=%b respawn=%b, required 5 1 0",
                     bus.LIVES_COUNTER_count_Out, bus.LIVES_COUNTER_gameover_OutHigh,
                     bus.LIVES_COUNTER_respawn_OutHigh);
        end
        bus.LIVES_COUNTER_restart_InHigh = 1'b1;
        step();
        bus.LIVES_COUNTER_restart_InHigh = 1'b0;
        testsRun++;
        if (bus.LIVES_COUNTER_count_Out !== 3'd0 || bus.LIVES_COUNTER_gameover_OutHigh !== 1'b0 ||
            bus.LIVES_COUNTER_respawn_OutHigh !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL restart: count=%0d gameover=%b respawn=%b, required 0 0 1",
                     bus.LIVES_COUNTER_count_Out, bus.LIVES_COUNTER_gameover_OutHigh,
                     bus.LIVES_COUNTER_respawn_OutHigh);
        end
        step();
        testsRun++;
        if (bus.LIVES_COUNTER_respawn_OutHigh !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL restart_pulse_width: respawn=%b, required 0",
                     bus.LIVES_COUNTER_respawn_OutHigh);
        end
        $display("[TB] test_game_over done");
    endtask

    task automatic test_bonus();
        do_reset();
        repeat (2) death_and_recover();
        bus.LIVES_COUNTER_bonus_InHigh = 1'b1;
        step();
        testsRun++;
        if (bus.LIVES_COUNTER_count_Out !== 3'd1) begin
            testsFailed++;
            $display("[TB] FAIL bonus_from2: count=%0d, required 1", bus.LIVES_COUNTER_count_Out);
        end
        step();
        step();
        bus.LIVES_COUNTER_bonus_InHigh = 1'b0;
        testsRun++;
        if (bus.LIVES_COUNTER_count_Out !== 3'd0) begin
            testsFailed++;
            $display("[TB] FAIL bonus_saturate: count=%0d, required 0", bus.LIVES_COUNTER_count_Out);
        end
        bus.LIVES_COUNTER_death_InHigh = 1'b1;
        step();
        bus.LIVES_COUNTER_death_InHigh = 1'b0;
        bus.LIVES_COUNTER_bonus_InHigh = 1'b1;
        step();
        step();
        bus.LIVES_COUNTER_bonus_InHigh = 1'b0;
        testsRun++;
        if (bus.LIVES_COUNTER_count_Out !== 3'd1 || bus.LIVES_COUNTER_dying_OutHigh !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL bonus_in_dying: count=%0d dying=%b, required 1 1",
                     bus.LIVES_COUNTER_count_Out, bus.LIVES_COUNTER_dying_OutHigh);
        end
        $display("[TB] test_bonus done");
    endtask

    task automatic test_death_bonus_same_cycle();
        do_reset();
        death_and_recover();
        bus.LIVES_COUNTER_death_InHigh = 1'b1;
        bus.LIVES_COUNTER_bonus_InHigh = 1'b1;
        step();
        bus.LIVES_COUNTER_death_InHigh = 1'b0;
        bus.LIVES_COUNTER_bonus_InHigh = 1'b0;
        testsRun++;
        if (bus.LIVES_COUNTER_count_Out !== 3'd2 || bus.LIVES_COUNTER_dying_OutHigh !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL death_wins: count=%0d dying=%b, required 2 1",
                     bus.LIVES_COUNTER_count_Out, bus.LIVES_COUNTER_dying_OutHigh);
        end
        $display("[TB] test_death_bonus_same_cycle done");
    endtask

    task automatic test_reset_mid_dying();
        do_reset();
        bus.LIVES_COUNTER_death_InHigh = 1'b1;
        step();
        bus.LIVES_COUNTER_death_InHigh = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        testsRun++;
        if (bus.LIVES_COUNTER_count_Out !== 3'd0 || bus.LIVES_COUNTER_dying_OutHigh !== 1'b0 ||
            bus.LIVES_COUNTER_respawn_OutHigh !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_dying: count=%0d dying=%b respawn=%b, required 0 0 0",
                     bus.LIVES_COUNTER_count_Out, bus.LIVES_COUNTER_dying_OutHigh,
                     bus.LIVES_COUNTER_respawn_OutHigh);
        end
        repeat (4) step();
        testsRun++;
        if (bus.LIVES_COUNTER_respawn_OutHigh !== 1'b0 || bus.LIVES_COUNTER_dying_OutHigh !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_no_respawn: respawn=%b dying=%b, required 0 0",
                     bus.LIVES_COUNTER_respawn_OutHigh, bus.LIVES_COUNTER_dying_OutHigh);
        end
        bus.LIVES_COUNTER_death_InHigh = 1'b1;
        step();
        bus.LIVES_COUNTER_death_InHigh = 1'b0;
        testsRun++;
        if (bus.LIVES_COUNTER_count_Out !== 3'd1 || bus.LIVES_COUNTER_dying_OutHigh !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_back_to_playing: count=%0d dying=%b, required 1 1",
                     bus.LIVES_COUNTER_count_Out, bus.LIVES_COUNTER_dying_OutHigh);
        end
        $display("[TB] test_reset_mid_dying done");
    endtask

    task automatic test_restart_ignored();
        do_reset();
        bus.LIVES_COUNTER_restart_InHigh = 1'b1;
        step();
        testsRun++;
        if (bus.LIVES_COUNTER_respawn_OutHigh !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL restart_in_playing: respawn=%b, required 0",
                     bus.LIVES_COUNTER_respawn_OutHigh);
        end
        bus.LIVES_COUNTER_restart_InHigh = 1'b0;
        $display("[TB] test_restart_ignored done");
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst = 1'b1;
        bus.LIVES_COUNTER_death_InHigh   = 1'b0;
        bus.LIVES_COUNTER_bonus_InHigh   = 1'b0;
        bus.LIVES_COUNTER_restart_InHigh = 1'b0;
        test_reset();
        test_single_death();
        test_held_death();
        test_game_over();
        test_bonus();
        test_death_bonus_same_cycle();
        test_reset_mid_dying();
        test_restart_ignored();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
